// File: rtl/pipelined_control_unit.sv
// Registered MIPS control decoder: decodes the ID instruction and carries its control
// fields through ID/EX, EX/MEM and MEM/WB, with bubble insertion and a mul/div sequencer.
module pipelined_control_unit #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INS,
  input  logic        INS_VALID,
  input  logic        Stall,
  input  logic        Flush,
  output logic        Hold_ID,
  output logic [3:0]  EX_ALUC,
  output logic [1:0]  EX_ASEL,
  output logic        EX_BSEL,
  output logic        EX_IMM_ctrl,
  output logic [3:0]  EX_BR,
  output logic        EX_PCmux,
  output logic        EX_MD_start,
  output logic [1:0]  MEM_DMC,
  output logic [2:0]  MEM_Lmode,
  output logic        WB_WBmux,
  output logic        WB_WE,
  output logic [1:0]  WB_RDSEL,
  output logic        MD_busy,
  output logic        ILL_INS
);

  localparam logic [3:0] ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3, ALU_OR = 4'd4,
                         ALU_XOR = 4'd5, ALU_NOR = 4'd6, ALU_SLT = 4'd7, ALU_SLTU = 4'd8,
                         ALU_SLL = 4'd9, ALU_SRL = 4'd10, ALU_SRA = 4'd11, ALU_LUI = 4'd12,
                         ALU_MUL = 4'd13, ALU_DIV = 4'd14, ALU_MFHL = 4'd15;
  localparam logic [3:0] BR_LTZ = 4'd5, BR_GEZ = 4'd6, BR_J = 4'd7, BR_JR = 4'd8;
  localparam logic [1:0] A_SHAMT = 2'd1, A_PC = 2'd2;
  localparam logic [1:0] RD_RT = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] DM_READ = 2'd1, DM_WRITE = 2'd2;
  localparam logic [2:0] LM_B = 3'd1, LM_BU = 3'd2, LM_H = 3'd3, LM_HU = 3'd4, LM_W = 3'd5;

  typedef struct packed {
    logic       wbmux;
    logic       we;
    logic [1:0] rdsel;
  } wb_t;

  typedef struct packed {
    logic [1:0] dmc;
    logic [2:0] lmode;
    wb_t        wb;
  } mem_t;

  typedef struct packed {
    logic [3:0] aluc;
    logic [1:0] asel;
    logic       bsel;
    logic       imm;
    logic [3:0] br;
    logic       pcmux;
    logic       md;
    logic       ill;
    mem_t       mem;
  } ctrl_t;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  ctrl_t      dec, ex_d, ex_q;
  mem_t       mem_q;
  wb_t        wb_q;
  logic       is_hilo, int_hold, load;
  logic [5:0] op, fn;
  md_state_t  md_state;
  logic [CNT_W-1:0] md_cnt;

  assign op = INS[31:26];
  assign fn = INS[5:0];

  // MFHI/MFLO reuse BSEL to pick HI (1) or LO (0); mul/div use IMM_ctrl as the signed flag.
  always_comb begin
    dec     = '0;
    dec.ill = 1'b1;
    is_hilo = 1'b0;
    if (INS == 32'h0) begin
      dec.ill = 1'b0;
    end else begin
      case (op)
        6'h00: begin
          dec.ill       = 1'b0;
          dec.mem.wb.we = 1'b1;
          case (fn)
            6'h20, 6'h21: dec.aluc = ALU_ADD;
            6'h22, 6'h23: dec.aluc = ALU_SUB;
            6'h24: dec.aluc = ALU_AND;
            6'h25: dec.aluc = ALU_OR;
            6'h26: dec.aluc = ALU_XOR;
            6'h27: dec.aluc = ALU_NOR;
            6'h2A: dec.aluc = ALU_SLT;
            6'h2B: dec.aluc = ALU_SLTU;
            6'h00: begin dec.aluc = ALU_SLL; dec.asel = A_SHAMT; end
            6'h02: begin dec.aluc = ALU_SRL; dec.asel = A_SHAMT; end
            6'h03: begin dec.aluc = ALU_SRA; dec.asel = A_SHAMT; end
            6'h04: dec.aluc = ALU_SLL;
            6'h06: dec.aluc = ALU_SRL;
            6'h07: dec.aluc = ALU_SRA;
            6'h08: begin dec.mem.wb.we = 1'b0; dec.br = BR_JR; dec.pcmux = 1'b1; end
            6'h09: begin
              dec.aluc = ALU_ADD; dec.asel = A_PC; dec.br = BR_JR; dec.pcmux = 1'b1;
            end
            6'h18, 6'h19, 6'h1A, 6'h1B: begin
              dec.mem.wb.we = 1'b0;
              dec.aluc      = fn[1] ? ALU_DIV : ALU_MUL;
              dec.imm       = ~fn[0];
              dec.md        = 1'b1;
              is_hilo       = 1'b1;
            end
            6'h10, 6'h12: begin dec.aluc = ALU_MFHL; dec.bsel = ~fn[1]; is_hilo = 1'b1; end
            default: begin dec.ill = 1'b1; dec.mem.wb.we = 1'b0; end
          endcase
        end
        6'h01: if (INS[20:17] == 4'h0) begin
          dec.ill = 1'b0; dec.aluc = ALU_SUB; dec.imm = 1'b1; dec.pcmux = 1'b1;
          dec.br  = INS[16] ? BR_GEZ : BR_LTZ;
        end
        6'h02: begin dec.ill = 1'b0; dec.br = BR_J; dec.pcmux = 1'b1; end
        6'h03: begin
          dec.ill = 1'b0; dec.br = BR_J; dec.pcmux = 1'b1; dec.aluc = ALU_ADD;
          dec.asel = A_PC; dec.mem.wb.we = 1'b1; dec.mem.wb.rdsel = RD_RA;
        end
        6'h04, 6'h05, 6'h06, 6'h07: begin
          dec.ill = 1'b0; dec.aluc = ALU_SUB; dec.imm = 1'b1; dec.pcmux = 1'b1;
          dec.br  = {2'b00, op[1:0]} + 4'd1;
        end
        6'h08, 6'h09, 6'h0A, 6'h0B: begin
          dec.ill = 1'b0; dec.bsel = 1'b1; dec.imm = 1'b1;
          dec.mem.wb.we = 1'b1; dec.mem.wb.rdsel = RD_RT;
          dec.aluc = op[1] ? (op[0] ? ALU_SLTU : ALU_SLT) : ALU_ADD;
        end
        6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
          dec.ill = 1'b0; dec.bsel = 1'b1;
          dec.mem.wb.we = 1'b1; dec.mem.wb.rdsel = RD_RT;
          case (op[1:0])
            2'd0:    dec.aluc = ALU_AND;
            2'd1:    dec.aluc = ALU_OR;
            2'd2:    dec.aluc = ALU_XOR;
            default: dec.aluc = ALU_LUI;
          endcase
        end
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
          dec.ill = 1'b0; dec.aluc = ALU_ADD; dec.bsel = 1'b1; dec.imm = 1'b1;
          dec.mem.dmc = DM_READ; dec.mem.wb.wbmux = 1'b1;
          dec.mem.wb.we = 1'b1; dec.mem.wb.rdsel = RD_RT;
          case (op[2:0])
            3'd0:    dec.mem.lmode = LM_B;
            3'd4:    dec.mem.lmode = LM_BU;
            3'd1:    dec.mem.lmode = LM_H;
            3'd5:    dec.mem.lmode = LM_HU;
            default: dec.mem.lmode = LM_W;
          endcase
        end
        6'h28, 6'h29, 6'h2B: begin
          dec.ill = 1'b0; dec.aluc = ALU_ADD; dec.bsel = 1'b1; dec.imm = 1'b1;
          dec.mem.dmc = DM_WRITE;
          case (op[1:0])
            2'd0:    dec.mem.lmode = LM_B;
            2'd1:    dec.mem.lmode = LM_H;
            default: dec.mem.lmode = LM_W;
          endcase
        end
        default: ;
      endcase
    end
  end

  // A flushed instruction never needs to wait on HI/LO; fetch replaces it.
  assign int_hold = MD_busy & is_hilo & INS_VALID & ~Flush;
  assign Hold_ID  = Stall | int_hold;
  assign load     = INS_VALID & ~Stall & ~Flush & ~int_hold;
  assign ex_d     = load ? dec : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q.mem;
      wb_q  <= mem_q.wb;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      case (md_state)
        MD_IDLE: if (ex_d.md && MULDIV_LAT > 1) begin
          md_state <= MD_BUSY;
          md_cnt   <= CNT_W'(MULDIV_LAT - 1);
        end
        MD_BUSY: begin
          if (md_cnt == '0) md_state <= MD_IDLE;
          else              md_cnt   <= md_cnt - 1'b1;
        end
        default: md_state <= MD_IDLE;
      endcase
    end
  end

  assign MD_busy     = (md_state == MD_BUSY);
  assign EX_ALUC     = ex_q.aluc;
  assign EX_ASEL     = ex_q.asel;
  assign EX_BSEL     = ex_q.bsel;
  assign EX_IMM_ctrl = ex_q.imm;
  assign EX_BR       = ex_q.br;
  assign EX_PCmux    = ex_q.pcmux;
  assign EX_MD_start = ex_q.md;
  assign ILL_INS     = ex_q.ill;
  assign MEM_DMC     = mem_q.dmc;
  assign MEM_Lmode   = mem_q.lmode;
  assign WB_WBmux    = wb_q.wbmux;
  assign WB_WE       = wb_q.we;
  assign WB_RDSEL    = wb_q.rdsel;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: instruction-template table, directed corner sequences
// and randomized traffic checked against a cycle-level queue/counter reference model.
module tb_pipelined_control_unit;
  localparam int LAT = 4;

  logic        CLK = 1'b0, RESET, INS_VALID, Stall, Flush;
  logic [31:0] INS;
  logic        Hold_ID, EX_BSEL, EX_IMM_ctrl, EX_PCmux, EX_MD_start, WB_WBmux, WB_WE;
  logic        MD_busy, ILL_INS;
  logic [3:0]  EX_ALUC, EX_BR;
  logic [1:0]  EX_ASEL, MEM_DMC, WB_RDSEL;
  logic [2:0]  MEM_Lmode;

  pipelined_control_unit #(.MULDIV_LAT(LAT), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .INS(INS), .INS_VALID(INS_VALID), .Stall(Stall),
    .Flush(Flush), .Hold_ID(Hold_ID), .EX_ALUC(EX_ALUC), .EX_ASEL(EX_ASEL),
    .EX_BSEL(EX_BSEL), .EX_IMM_ctrl(EX_IMM_ctrl), .EX_BR(EX_BR), .EX_PCmux(EX_PCmux),
    .EX_MD_start(EX_MD_start), .MEM_DMC(MEM_DMC), .MEM_Lmode(MEM_Lmode),
    .WB_WBmux(WB_WBmux), .WB_WE(WB_WE), .WB_RDSEL(WB_RDSEL), .MD_busy(MD_busy),
    .ILL_INS(ILL_INS));

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic [31:0] base, mask;
    logic [3:0]  aluc;
    logic [1:0]  asel;
    logic        bsel, imm;
    logic [3:0]  br;
    logic        pcmux;
    logic [1:0]  dmc;
    logic [2:0]  lmode;
    logic        wbmux, we;
    logic [1:0]  rdsel;
    logic        md, hilo, ill;
  } vec_t;

  localparam int NT = 24;
  localparam logic [31:0] RM = 32'h03FF_FFC0, IM = 32'h03FF_FFFF;
  vec_t tbl[NT];
  vec_t bub, ex_e, mem_e, wb_e;
  int   md_left, n_chk, n_fail;

  function automatic vec_t mk(string nm, logic [31:0] base, logic [31:0] mask,
      logic [3:0] aluc, logic [1:0] asel, logic bsel, logic imm, logic [3:0] br,
      logic pcmux, logic [1:0] dmc, logic [2:0] lmode, logic wbmux, logic we,
      logic [1:0] rdsel, logic md, logic hilo, logic ill);
    vec_t v;
    v.nm = nm; v.base = base; v.mask = mask; v.aluc = aluc; v.asel = asel;
    v.bsel = bsel; v.imm = imm; v.br = br; v.pcmux = pcmux; v.dmc = dmc;
    v.lmode = lmode; v.wbmux = wbmux; v.we = we; v.rdsel = rdsel;
    v.md = md; v.hilo = hilo; v.ill = ill;
    return v;
  endfunction

  function automatic logic [31:0] gen(int i);
    return tbl[i].base | ($urandom & tbl[i].mask);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm);
    chk({nm, ".ex"}, 32'({EX_ALUC, EX_ASEL, EX_BSEL, EX_IMM_ctrl, EX_BR, EX_PCmux,
                          EX_MD_start, ILL_INS}),
                     32'({ex_e.aluc, ex_e.asel, ex_e.bsel, ex_e.imm, ex_e.br, ex_e.pcmux,
                          ex_e.md, ex_e.ill}));
    chk({nm, ".mem"}, 32'({MEM_DMC, MEM_Lmode}), 32'({mem_e.dmc, mem_e.lmode}));
    chk({nm, ".wb"}, 32'({WB_WBmux, WB_WE, WB_RDSEL}), 32'({wb_e.wbmux, wb_e.we, wb_e.rdsel}));
    chk({nm, ".busy"}, 32'(MD_busy), 32'(md_left > 0));
  endtask

  // One ID cycle: apply inputs, check Hold_ID, clock, advance model, check stages.
  task automatic step(int i, logic v, logic st, logic fl, logic [31:0] ins);
    logic hold_int, enters;
    INS = ins; INS_VALID = v; Stall = st; Flush = fl;
    #1;
    hold_int = (md_left > 0) && tbl[i].hilo && v && !fl;
    enters   = v && !st && !fl && !hold_int;
    chk({tbl[i].nm, ".hold"}, 32'(Hold_ID), 32'(st | hold_int));
    @(posedge CLK); #1;
    wb_e  = mem_e;
    mem_e = ex_e;
    ex_e  = enters ? tbl[i] : bub;
    if (md_left > 0) md_left--;
    if (enters && tbl[i].md && LAT > 1) md_left = LAT;
    check_all(tbl[i].nm);
  endtask

  task automatic clear_model();
    ex_e = bub; mem_e = bub; wb_e = bub; md_left = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; INS = '0; INS_VALID = 1'b0; Stall = 1'b0; Flush = 1'b0;
    @(posedge CLK); #1;
    clear_model();
    check_all("reset");
    #2 RESET = 1'b0;
  endtask

  localparam int I_ADD = 0, I_MULT = 7, I_MFLO = 10, I_LW = 14, I_BEQ = 17;
  localparam int I_ILL = 20, I_NOP = 21, I_SW = 23;

  initial begin
    int busy_cnt, start_cnt;
    n_chk = 0; n_fail = 0;
    bub     = mk("bub", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = mk("add",   32'h0000_0020, RM, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk("subu",  32'h0000_0023, RM, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk("nor",   32'h0000_0027, RM, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk("sltu",  32'h0000_002B, RM, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk("sll",   32'h0000_0800, RM, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk("srav",  32'h0000_0007, RM, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk("jalr",  32'h0000_0009, RM, 1, 2, 0, 0, 8, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk("mult",  32'h0000_0018, RM, 13, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[8]  = mk("divu",  32'h0000_001B, RM, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[9]  = mk("mfhi",  32'h0000_0010, RM, 15, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[10] = mk("mflo",  32'h0000_0012, RM, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[11] = mk("addiu", 32'h2400_0000, IM, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[12] = mk("ori",   32'h3400_0000, IM, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[13] = mk("lui",   32'h3C00_0000, IM, 12, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[14] = mk("lw",    32'h8C00_0000, IM, 1, 0, 1, 1, 0, 0, 1, 5, 1, 1, 1, 0, 0, 0);
    tbl[15] = mk("lbu",   32'h9000_0000, IM, 1, 0, 1, 1, 0, 0, 1, 2, 1, 1, 1, 0, 0, 0);
    tbl[16] = mk("sh",    32'hA400_0000, IM, 1, 0, 1, 1, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk("beq",   32'h1000_0000, IM, 2, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk("bgez",  32'h0401_0000, 32'h03E0_FFFF, 2, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk("jal",   32'h0C00_0000, IM, 1, 2, 0, 0, 7, 1, 0, 0, 0, 1, 2, 0, 0, 0);
    tbl[20] = mk("ill",   32'hFC00_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[21] = mk("nop",   32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk("illfn", 32'h0000_0001, RM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[23] = mk("sw",    32'hAC00_0000, IM, 1, 0, 1, 1, 0, 0, 2, 5, 0, 0, 0, 0, 0, 0);

    do_reset();

    // ADD: EX after 1st edge, WB after 3rd
    step(I_ADD, 1, 0, 0, 32'h0022_1820);
    chk("add.aluc", 32'(EX_ALUC), 32'd1);
    chk("add.bsel", 32'(EX_BSEL), 32'd0);
    step(I_NOP, 0, 0, 0, 32'h0);
    step(I_NOP, 0, 0, 0, 32'h0);
    chk("add.wbwe", 32'({WB_WE, WB_WBmux}), 32'b10);

    // LW through MEM and WB
    step(I_LW, 1, 0, 0, 32'h8C24_0008);
    chk("lw.ex", 32'({EX_BSEL, EX_IMM_ctrl}), 32'b11);
    step(I_NOP, 0, 0, 0, 32'h0);
    chk("lw.mem", 32'({MEM_DMC, MEM_Lmode}), 32'({2'd1, 3'd5}));
    step(I_NOP, 0, 0, 0, 32'h0);
    chk("lw.wb", 32'({WB_WE, WB_WBmux}), 32'b11);

    // SW stalled two cycles, then enters EX
    step(I_SW, 1, 1, 0, 32'hAC24_0008);
    step(I_SW, 1, 1, 0, 32'hAC24_0008);
    chk("sw.stall_ex", 32'({EX_ALUC, EX_BSEL}), 32'd0);
    step(I_SW, 1, 0, 0, 32'hAC24_0008);
    chk("sw.enter", 32'(EX_BSEL), 32'd1);
    step(I_NOP, 0, 0, 0, 32'h0);
    chk("sw.mem", 32'(MEM_DMC), 32'd2);

    // MULT then MFLO held behind the busy unit
    busy_cnt = 0; start_cnt = 0;
    step(I_MULT, 1, 0, 0, 32'h0022_0018);
    busy_cnt += int'(MD_busy); start_cnt += int'(EX_MD_start);
    for (int k = 0; k < 6; k++) begin
      step(I_MFLO, 1, 0, 0, 32'h0000_2012);
      busy_cnt += int'(MD_busy); start_cnt += int'(EX_MD_start);
    end
    chk("mult.busy_cycles", busy_cnt, LAT);
    chk("mult.start_pulses", start_cnt, 1);
    for (int k = 0; k < 3; k++) step(I_NOP, 0, 0, 0, 32'h0);

    // Flush and Stall together on a branch
    step(I_BEQ, 1, 1, 1, 32'h1022_0004);
    chk("beq.bubble", 32'({EX_PCmux, EX_BR}), 32'd0);

    // Illegal instruction pulses ILL_INS once
    step(I_ILL, 1, 0, 0, 32'hFC00_0000);
    chk("ill.pulse", 32'(ILL_INS), 32'd1);
    step(I_NOP, 0, 0, 0, 32'h0);
    chk("ill.clear", 32'(ILL_INS), 32'd0);

    // Asynchronous reset mid-operation
    step(I_MULT, 1, 0, 0, 32'h0022_0018);
    step(I_NOP, 0, 0, 0, 32'h0);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid.busy", 32'(MD_busy), 32'd0);
    chk("rst_mid.ex", 32'({EX_ALUC, EX_MD_start, MEM_DMC, WB_WE}), 32'd0);
    clear_model();
    @(negedge CLK) RESET = 1'b0;

    // Table sweep: each template once, drained through WB
    for (int i = 0; i < NT; i++) begin
      step(i, 1, 0, 0, gen(i));
      for (int k = 0; k < (tbl[i].md ? LAT : 0) + 2; k++) step(I_NOP, 0, 0, 0, 32'h0);
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int i;
      i = $urandom_range(0, NT - 1);
      step(i, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, gen(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
